mastermind_ctrl: RTL and testbench

Game controller for the Mastermind board. It takes debounced single-cycle button pulses, runs the game state machine, holds the 6×4 guess matrix, and scores each committed row against a secret code. It produces every game-state signal the downstream VGA renderer consumes: `matrix_flat`, `guess_num`, `q_Input`, `cursor_index`, `current_color` and `q_DoneC`.

---
 rtl/mastermind_pkg.sv | 58 +++++
 rtl/mastermind_score.sv | 64 ++++++
 rtl/mastermind_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_mastermind_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mastermind_pkg.sv
// Shared Mastermind types, geometry constants and colour helpers.
// Latency: none (declarations and pure functions only).
// Backpressure: n/a.
package mastermind_pkg;

  localparam int ROWS  = 6;
  localparam int COLS  = 4;
  localparam int ROW_W = 12;
  localparam int FB_W  = 6;

  typedef enum logic [2:0] {
    S_INIT,
    S_INPUT,
    S_CHECK,
    S_DONEC,
    S_DONEF
  } state_e;

  typedef enum logic [2:0] {
    EMPTY   = 3'd0,
    BLUE    = 3'd1,
    GREEN   = 3'd2,
    RED     = 3'd3,
    YELLOW  = 3'd4,
    CYAN    = 3'd5,
    MAGENTA = 3'd6
  } color_e;

  localparam logic [2:0] COLOR_FIRST = 3'd1;
  localparam logic [2:0] COLOR_LAST  = 3'd6;

  // Colour code to 12-bit RGB (4 bits per channel); shared with the renderer.
  function automatic logic [11:0] color_rgb(input logic [2:0] c);
    case (c)
      3'd1:    color_rgb = 12'h00F;
      3'd2:    color_rgb = 12'h0F0;
      3'd3:    color_rgb = 12'hF00;
      3'd4:    color_rgb = 12'hFF0;
      3'd5:    color_rgb = 12'h0FF;
      3'd6:    color_rgb = 12'hF0F;
      default: color_rgb = 12'h000;
    endcase
  endfunction

  // Number of pegs in a packed row that carry the given colour (0..4).
  function automatic logic [2:0] digit_count(input logic [11:0] row,
                                             input logic [2:0]  color);
    digit_count = 3'd0;
    for (int c = 0; c < 4; c++) begin
      if (row[c*3 +: 3] == color) digit_count = digit_count + 3'd1;
    end
  endfunction

  function automatic logic [2:0] min3(input logic [2:0] a, input logic [2:0] b);
    min3 = (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/mastermind_score.sv
// Seven-step guess scorer: exact matches, then per-colour min-count accumulation.
// Latency: done is high in the 7th cycle after the start edge (steps 0..6).
// Backpressure: none; guess and secret must stay stable while busy.
//
// Ports: clk, reset (sync, active-high), start (pulse), guess/secret (12-bit
// packed rows), done (one cycle), exact/partial (valid while done is high).
module mastermind_score
  import mastermind_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] guess,
  input  logic [11:0] secret,
  output logic        done,
  output logic [2:0]  exact,
  output logic [2:0]  partial
);

  logic       busy_q;
  logic [2:0] step_q;
  logic [2:0] exact_q;
  logic [2:0] sum_q;
  logic [2:0] exact_now;
  logic [2:0] sum_next;

  always_comb begin
    exact_now = 3'd0;
    for (int c = 0; c < 4; c++) begin
      if (guess[c*3 +: 3] == secret[c*3 +: 3]) exact_now = exact_now + 3'd1;
    end
    // Step k (1..6) scores colour k; the step-0 value of this term is never used.
    sum_next = sum_q + min3(digit_count(guess, step_q), digit_count(secret, step_q));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= 1'b0;
      step_q  <= 3'd0;
      exact_q <= 3'd0;
      sum_q   <= 3'd0;
    end else if (start) begin
      busy_q <= 1'b1;
      step_q <= 3'd0;
      sum_q  <= 3'd0;
    end else if (busy_q) begin
      if (step_q == 3'd0) exact_q <= exact_now;
      else                sum_q   <= sum_next;
      if (step_q == 3'd6) begin
        busy_q <= 1'b0;
        step_q <= 3'd0;
      end else begin
        step_q <= step_q + 3'd1;
      end
    end
  end

  // The final colour term is folded in combinationally so the result is
  // available during step 6 itself.
  assign done    = busy_q && (step_q == 3'd6);
  assign exact   = exact_q;
  assign partial = sum_next - exact_q;

endmodule

// File: rtl/mastermind_ctrl.sv
// Mastermind game controller: button FSM, guess matrix, feedback and secret.
// Latency: every effect registered one cycle after its pulse; scoring 1+7 cycles.
// Backpressure: none; pulses in CHECK (and non-C pulses in INIT/DONE) are dropped.
//
// Ports: clk, reset (sync, active-high), btnC/btnL/btnU/btnD (1-cycle pulses),
// secret_in (absent with MASTERMIND_LFSR_SECRET_EN), matrix_flat, feedback_flat,
// guess_num, cursor_index, current_color, one-hot q_Init/q_Input/q_Check/q_DoneC/q_DoneF.
// Build option: define MASTERMIND_LFSR_SECRET_EN to draw the secret from an internal LFSR.
module mastermind_ctrl #(
  parameter int ROWS = 6,
  parameter int COLS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btnC,
  input  logic                 btnL,
  input  logic                 btnU,
  input  logic                 btnD,
`ifndef MASTERMIND_LFSR_SECRET_EN
  input  logic [11:0]          secret_in,
`endif
  output logic [ROWS*12-1:0]   matrix_flat,
  output logic [ROWS*6-1:0]    feedback_flat,
  output logic [2:0]           guess_num,
  output logic [1:0]           cursor_index,
  output logic [2:0]           current_color,
  output logic                 q_Init,
  output logic                 q_Input,
  output logic                 q_Check,
  output logic                 q_DoneC,
  output logic                 q_DoneF
);

  import mastermind_pkg::*;

  localparam logic [1:0] LAST_COL = 2'(COLS - 1);
  localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);

  state_e                 state_q, state_d;
  logic [ROWS*12-1:0]     matrix_d;
  logic [ROWS*6-1:0]      feedback_d;
  logic [2:0]             guess_d;
  logic [1:0]             cursor_d;
  logic [2:0]             color_d;
  logic [11:0]            secret_q, secret_d, new_secret;
  logic [11:0]            guess_row;
  logic                   score_start;
  logic                   score_done;
  logic [2:0]             score_exact;
  logic [2:0]             score_partial;
  int                     slot;

`ifdef MASTERMIND_LFSR_SECRET_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11; free-running so the secret depends on
  // how long the player waits before starting.
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_comb begin
    new_secret = 12'd0;
    for (int c = 0; c < 4; c++) begin
      new_secret[c*3 +: 3] = 3'(lfsr_q[c*4 +: 4] % 4'd6) + 3'd1;
    end
  end
`else
  // Digits outside 1..6 would never be matchable, so they are forced to 1.
  always_comb begin
    new_secret = 12'd0;
    for (int c = 0; c < 4; c++) begin
      if (secret_in[c*3 +: 3] == 3'd0 || secret_in[c*3 +: 3] == 3'd7)
        new_secret[c*3 +: 3] = 3'd1;
      else
        new_secret[c*3 +: 3] = secret_in[c*3 +: 3];
    end
  end
`endif

  assign guess_row = matrix_flat[int'(guess_num)*ROW_W +: ROW_W];

  mastermind_score u_score (
    .clk     (clk),
    .reset   (reset),
    .start   (score_start),
    .guess   (guess_row),
    .secret  (secret_q),
    .done    (score_done),
    .exact   (score_exact),
    .partial (score_partial)
  );

  always_comb begin
    state_d     = state_q;
    matrix_d    = matrix_flat;
    feedback_d  = feedback_flat;
    guess_d     = guess_num;
    cursor_d    = cursor_index;
    color_d     = current_color;
    secret_d    = secret_q;
    score_start = 1'b0;
    slot        = int'(guess_num) * ROW_W + int'(cursor_index) * 3;

    case (state_q)
      S_INIT: begin
        if (btnC) begin
          secret_d   = new_secret;
          matrix_d   = '0;
          feedback_d = '0;
          guess_d    = 3'd0;
          cursor_d   = 2'd0;
          color_d    = COLOR_FIRST;
          state_d    = S_INPUT;
        end
      end
      S_INPUT: begin
        if (btnC) begin
          matrix_d[slot +: 3] = current_color;
          if (cursor_index == LAST_COL) begin
            // Scorer samples the row from the next cycle, after this write lands.
            score_start = 1'b1;
            state_d     = S_CHECK;
          end else begin
            cursor_d = cursor_index + 2'd1;
          end
        end else if (btnL) begin
          if (cursor_index != 2'd0) begin
            cursor_d                = cursor_index - 2'd1;
            matrix_d[slot - 3 +: 3] = EMPTY;
          end
        end else if (btnU) begin
          color_d = (current_color == COLOR_LAST) ? COLOR_FIRST : current_color + 3'd1;
        end else if (btnD) begin
          color_d = (current_color == COLOR_FIRST) ? COLOR_LAST : current_color - 3'd1;
        end
      end
      S_CHECK: begin
        if (score_done) begin
          feedback_d[int'(guess_num)*FB_W +: FB_W] = {score_partial, score_exact};
          if (score_exact == 3'd4) begin
            state_d = S_DONEC;
          end else if (guess_num == LAST_ROW) begin
            state_d = S_DONEF;
          end else begin
            guess_d  = guess_num + 3'd1;
            cursor_d = 2'd0;
            state_d  = S_INPUT;
          end
        end
      end
      S_DONEC, S_DONEF: begin
        if (btnC) state_d = S_INIT;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_INIT;
      matrix_flat   <= '0;
      feedback_flat <= '0;
      guess_num     <= 3'd0;
      cursor_index  <= 2'd0;
      current_color <= COLOR_FIRST;
      secret_q      <= 12'd0;
      q_Init        <= 1'b1;
      q_Input       <= 1'b0;
      q_Check       <= 1'b0;
      q_DoneC       <= 1'b0;
      q_DoneF       <= 1'b0;
    end else begin
      state_q       <= state_d;
      matrix_flat   <= matrix_d;
      feedback_flat <= feedback_d;
      guess_num     <= guess_d;
      cursor_index  <= cursor_d;
      current_color <= color_d;
      secret_q      <= secret_d;
      // Flags are registered from the next state so they never lag state_q.
      q_Init        <= (state_d == S_INIT);
      q_Input       <= (state_d == S_INPUT);
      q_Check       <= (state_d == S_CHECK);
      q_DoneC       <= (state_d == S_DONEC);
      q_DoneF       <= (state_d == S_DONEF);
    end
  end

endmodule

// File: tb/tb_mastermind_ctrl.sv
// Self-checking bench for mastermind_ctrl (default build, secret_in port present).
// Latency: n/a.
// Backpressure: n/a.
module tb_mastermind_ctrl;

  logic         clk = 1'b0;
  logic         reset, btnC, btnL, btnU, btnD;
  logic [11:0]  secret_in;
  logic [71:0]  matrix_flat;
  logic [35:0]  feedback_flat;
  logic [2:0]   guess_num;
  logic [1:0]   cursor_index;
  logic [2:0]   current_color;
  logic         q_Init, q_Input, q_Check, q_DoneC, q_DoneF;
  logic [4:0]   flags;

  assign flags = {q_DoneF, q_DoneC, q_Check, q_Input, q_Init};

  always #5 clk = ~clk;

  mastermind_ctrl #(.ROWS(6), .COLS(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .btnC          (btnC),
    .btnL          (btnL),
    .btnU          (btnU),
    .btnD          (btnD),
    .secret_in     (secret_in),
    .matrix_flat   (matrix_flat),
    .feedback_flat (feedback_flat),
    .guess_num     (guess_num),
    .cursor_index  (cursor_index),
    .current_color (current_color),
    .q_Init        (q_Init),
    .q_Input       (q_Input),
    .q_Check       (q_Check),
    .q_DoneC       (q_DoneC),
    .q_DoneF       (q_DoneF)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Game-level reference model: 0 INIT, 1 INPUT, 2 CHECK, 3 DONEC, 4 DONEF.
  int m_state, m_wait, m_guess, m_cursor, m_color;
  int m_board[6][4];
  int m_exact[6];
  int m_part[6];
  int m_secret[4];

  task automatic model_clear_board();
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 4; c++) m_board[r][c] = 0;
      m_exact[r] = 0;
      m_part[r]  = 0;
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_wait = 0; m_guess = 0; m_cursor = 0; m_color = 1;
    model_clear_board();
  endtask

  task automatic model_score();
    int ex, tot, cg, cs;
    ex  = 0;
    tot = 0;
    for (int c = 0; c < 4; c++) if (m_board[m_guess][c] == m_secret[c]) ex++;
    for (int k = 1; k <= 6; k++) begin
      cg = 0; cs = 0;
      for (int c = 0; c < 4; c++) begin
        if (m_board[m_guess][c] == k) cg++;
        if (m_secret[c] == k) cs++;
      end
      tot += (cg < cs) ? cg : cs;
    end
    m_exact[m_guess] = ex;
    m_part[m_guess]  = tot - ex;
    if (ex == 4)           m_state = 3;
    else if (m_guess == 5) m_state = 4;
    else begin
      m_guess++;
      m_cursor = 0;
      m_state  = 1;
    end
  endtask

  task automatic model_step(input bit r, input bit c, input bit l, input bit u, input bit d);
    int dig;
    if (r) begin
      model_reset();
      return;
    end
    case (m_state)
      0: if (c) begin
        for (int i = 0; i < 4; i++) begin
          dig = int'((secret_in >> (3 * i)) & 12'd7);
          m_secret[i] = (dig == 0 || dig == 7) ? 1 : dig;
        end
        model_clear_board();
        m_guess = 0; m_cursor = 0; m_color = 1; m_state = 1;
      end
      1: begin
        if (c) begin
          m_board[m_guess][m_cursor] = m_color;
          if (m_cursor == 3) begin
            m_state = 2;
            m_wait  = 0;
          end else m_cursor++;
        end else if (l) begin
          if (m_cursor > 0) begin
            m_cursor--;
            m_board[m_guess][m_cursor] = 0;
          end
        end else if (u) m_color = m_color % 6 + 1;
        else if (d)     m_color = (m_color + 4) % 6 + 1;
      end
      2: begin
        // Seven cycles are spent in CHECK; the verdict lands at the end of the last.
        if (m_wait < 6) m_wait++;
        else model_score();
      end
      default: if (c) m_state = 0;
    endcase
  endtask

  function automatic logic [71:0] exp_matrix();
    logic [71:0] v;
    v = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 4; c++) v[r*12 + c*3 +: 3] = 3'(m_board[r][c]);
    return v;
  endfunction

  function automatic logic [35:0] exp_feedback();
    logic [35:0] v;
    v = '0;
    for (int r = 0; r < 6; r++) v[r*6 +: 6] = {3'(m_part[r]), 3'(m_exact[r])};
    return v;
  endfunction

  task automatic tick(input bit r, input bit c, input bit l, input bit u, input bit d);
    reset = r; btnC = c; btnL = l; btnU = u; btnD = d;
    model_step(r, c, l, u, d);
    @(posedge clk);
    #1;
    reset = 1'b0; btnC = 1'b0; btnL = 1'b0; btnU = 1'b0; btnD = 1'b0;
    check_eq("flags",    72'(flags),         72'(5'd1 << m_state));
    check_eq("matrix",   matrix_flat,        exp_matrix());
    check_eq("feedback", 72'(feedback_flat), 72'(exp_feedback()));
    check_eq("guess",    72'(guess_num),     72'(m_guess));
    check_eq("cursor",   72'(cursor_index),  72'(m_cursor));
    check_eq("color",    72'(current_color), 72'(m_color));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
  endtask

  task automatic commit_color(input int col);
    for (int i = 0; i < 6 && m_color != col; i++) tick(0, 0, 0, 1, 0);
    tick(0, 1, 0, 0, 0);
  endtask

  task automatic guess4(input int a, input int b, input int c, input int d);
    commit_color(a); commit_color(b); commit_color(c); commit_color(d);
  endtask

  initial begin
    reset = 1'b1; btnC = 1'b0; btnL = 1'b0; btnU = 1'b0; btnD = 1'b0;
    secret_in = 12'h8D1;   // columns 0..3 = 1,2,3,4
    model_reset();

    tick(1, 0, 0, 0, 0);
    check_eq("rst_flags", 72'(flags), 72'(5'b00001));
    check_eq("rst_color", 72'(current_color), 72'(3'd1));

    // Crack the code on the first row.
    tick(0, 1, 0, 0, 0);
    guess4(1, 2, 3, 4);
    idle(6);
    check_eq("check_busy", 72'(q_Check), 72'(1'b1));
    idle(1);
    check_eq("crack_donec", 72'(q_DoneC), 72'(1'b1));
    check_eq("crack_fb",    72'(feedback_flat[5:0]), 72'(6'b000_100));
    check_eq("crack_guess", 72'(guess_num), 72'(3'd0));

    // DONEC -> INIT holds the board; the next start clears it.
    tick(0, 1, 0, 0, 0);
    check_eq("init_hold", 72'(matrix_flat[11:0]), 72'(12'h8D1));
    tick(0, 1, 0, 0, 0);
    check_eq("start_clr", matrix_flat, 72'd0);

    // All colours right, all positions wrong.
    guess4(4, 3, 2, 1);
    idle(7);
    check_eq("rev_fb",     72'(feedback_flat[5:0]), 72'(6'b100_000));
    check_eq("rev_input",  72'(q_Input), 72'(1'b1));
    check_eq("rev_guess",  72'(guess_num), 72'(3'd1));
    check_eq("rev_cursor", 72'(cursor_index), 72'(2'd0));

    // Repeated colour: only one exact, no partials.
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    guess4(1, 1, 1, 1);
    idle(7);
    check_eq("ones_fb", 72'(feedback_flat[5:0]), 72'(6'b000_001));

    // Exhaust remaining rows.
    for (int i = 0; i < 5; i++) begin
      guess4(2, 2, 2, 2);
      idle(7);
    end
    check_eq("fail_donef", 72'(q_DoneF), 72'(1'b1));
    check_eq("fail_guess", 72'(guess_num), 72'(3'd5));
    tick(0, 1, 0, 0, 0);
    check_eq("fail_init", 72'(q_Init), 72'(1'b1));
    tick(0, 1, 0, 0, 0);
    check_eq("fail_clr", matrix_flat, 72'd0);

    // Colour wrap, button priority and erase.
    tick(0, 0, 0, 0, 1);
    check_eq("down_wrap", 72'(current_color), 72'(3'd6));
    tick(0, 0, 0, 1, 0);
    check_eq("up_wrap", 72'(current_color), 72'(3'd1));
    tick(0, 1, 0, 1, 0);
    check_eq("cu_color",  72'(current_color), 72'(3'd1));
    check_eq("cu_cursor", 72'(cursor_index), 72'(2'd1));
    tick(0, 0, 0, 1, 0);
    tick(0, 1, 0, 0, 0);
    check_eq("pre_erase", 72'(matrix_flat[5:3]), 72'(3'd2));
    tick(0, 0, 1, 0, 0);
    check_eq("erase_cursor", 72'(cursor_index), 72'(2'd1));
    check_eq("erase_slot",   72'(matrix_flat[5:3]), 72'(3'd0));

    // Finish the row, then reset partway through scoring of the next.
    tick(0, 1, 0, 0, 0); tick(0, 1, 0, 0, 0); tick(0, 1, 0, 0, 0);
    idle(7);
    guess4(2, 2, 2, 2);
    idle(3);
    tick(1, 0, 0, 0, 0);
    check_eq("midrst_flags", 72'(flags), 72'(5'b00001));
    check_eq("midrst_fb",    72'(feedback_flat), 72'd0);
    check_eq("midrst_mat",   matrix_flat, 72'd0);
    // A stale scorer would finish here and corrupt state.
    tick(0, 1, 0, 0, 0);
    idle(6);

    // Randomized play against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) secret_in = 12'($urandom);
      tick($urandom_range(0, 399) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
